// File: rtl/avm_arb_pkg.sv
// Shared types for the AMS_I2C Avalon-MM arbiter.
// FSM states, operation codes, abort readdata.
package avm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } t_arb_state;

  typedef enum bit {
    OP_WRITE,
    OP_READ
  } t_operation;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first req at or after ptr.
// req/ptr in; onehot, idx, any out.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Two passes: ports at/after ptr, then the
  // wrapped ports below ptr.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[k] && (k >= int'(ptr))) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!any && req[k] && (k < int'(ptr))) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/avm_i2c_arbiter.sv
// Round-robin share of one AMS_I2C Avalon-MM port
// among NUM_REQ byte masters, with a waitrequest
// watchdog. Ports: i_req_* / o_req_* per requester,
// o_avm_* / i_avm_* downstream, o_timeout, o_grant.
module avm_i2c_arbiter
  import avm_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       i_avs_clk,
  input  logic                       i_avs_rst,
  input  logic [NUM_REQ*ADDR_W-1:0]  i_req_address,
  input  logic [NUM_REQ-1:0]         i_req_write,
  input  logic [NUM_REQ*8-1:0]       i_req_writedata,
  input  logic [NUM_REQ-1:0]         i_req_read,
  output logic [7:0]                 o_req_readdata,
  output logic [NUM_REQ-1:0]         o_req_waitrequest,
  output logic [ADDR_W-1:0]          o_avm_address,
  output logic                       o_avm_write,
  output logic [7:0]                 o_avm_writedata,
  output logic                       o_avm_read,
  input  logic [7:0]                 i_avm_readdata,
  input  logic                       i_avm_waitrequest,
  output logic                       o_timeout,
  output logic [$clog2(NUM_REQ)-1:0] o_grant
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_REQ - 1);

  t_arb_state          state, state_n;
  t_operation          op, op_n;
  logic [GW-1:0]       ptr, ptr_n;
  logic [GW-1:0]       grant, grant_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [7:0]          wdata, wdata_n;
  logic                rd, rd_n;
  logic                wr, wr_n;
  logic [NUM_REQ-1:0]  wait_r, wait_n;
  logic [7:0]          rdata, rdata_n;
  logic                tmo, tmo_n;
  logic [CW-1:0]       cnt, cnt_n;

  logic [NUM_REQ-1:0]  reqs;
  logic [NUM_REQ-1:0]  win_oh;
  logic [GW-1:0]       win_idx;
  logic                win_any;
  logic                win_rd;
  logic                abort;

  assign reqs   = i_req_read | i_req_write;
  assign win_rd = |(win_oh & i_req_read);
  assign abort  = (TIMEOUT_CYCLES != 0) &&
                  (cnt == CNT_LAST);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (reqs),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge i_avs_clk) begin
    if (i_avs_rst) begin
      state  <= IDLE;
      op     <= OP_WRITE;
      ptr    <= '0;
      grant  <= '0;
      addr   <= '0;
      wdata  <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      wait_r <= '1;
      rdata  <= '0;
      tmo    <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      op     <= op_n;
      ptr    <= ptr_n;
      grant  <= grant_n;
      addr   <= addr_n;
      wdata  <= wdata_n;
      rd     <= rd_n;
      wr     <= wr_n;
      wait_r <= wait_n;
      rdata  <= rdata_n;
      tmo    <= tmo_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    ptr_n   = ptr;
    grant_n = grant;
    addr_n  = addr;
    wdata_n = wdata;
    rd_n    = rd;
    wr_n    = wr;
    wait_n  = '1;
    rdata_n = rdata;
    tmo_n   = tmo;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (win_any) begin
          grant_n = win_idx;
          addr_n  = i_req_address[
            int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_n = i_req_writedata[
            int'(win_idx)*8 +: 8];
          // Read wins over a simultaneous write.
          op_n    = win_rd ? OP_READ : OP_WRITE;
          rd_n    = win_rd;
          wr_n    = !win_rd;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!i_avm_waitrequest) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
          rdata_n = (op == OP_READ) ?
                    i_avm_readdata : 8'h00;
          wait_n[grant] = 1'b0;
          state_n = DONE;
        end else if (abort) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
          rdata_n = TIMEOUT_DATA;
          tmo_n   = 1'b1;
          wait_n[grant] = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        ptr_n   = (grant == LAST_PORT) ?
                  '0 : grant + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_req_readdata    = rdata;
  assign o_req_waitrequest = wait_r;
  assign o_avm_address     = addr;
  assign o_avm_write       = wr;
  assign o_avm_writedata   = wdata;
  assign o_avm_read        = rd;
  assign o_timeout         = tmo;
  assign o_grant           = grant;

endmodule
